// File: rtl/filtn_pkg.sv
// Shared definitions for the filtn glitch filter: FSM state encoding and
// the counter-width helper used by each channel.
package filtn_pkg;

  localparam logic FS_IDLE = 1'b0;
  localparam logic FS_PEND = 1'b1;

  // Counter must hold 0..n-1 and is never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/filtn_ch.sv
// One filtn channel: optional synchroniser, run counter, two-state FSM,
// filtered level and (with FILTN_EDGE_EN defined) registered edge pulses.
module filtn_ch
  import filtn_pkg::*;
#(
  parameter int   N           = 3,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic i,
  output logic y
`ifdef FILTN_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int              CW      = cnt_width(N);
  localparam logic [CW-1:0]   CNT_MAX = CW'(N - 1);

  logic d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign d = i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      assign sync_d[0] = i;
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_shift
        assign sync_d[gi] = sync_q[gi-1];
      end

      // Shifts every cycle; ce only gates the filter itself.
      always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{INIT}};
        else     sync_q <= sync_d;
      end

      assign d = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d;
  logic          run_done;

  assign run_done = (state_q == FS_PEND) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      cnt_q   <= '0;
      y_q     <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ce) begin
      if (d == y_q || run_done) state_d = FS_IDLE;
      else                      state_d = FS_PEND;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    y_d   = y_q;
    if (ce) begin
      if (d == y_q) begin
        cnt_d = '0;
      end else if (run_done) begin
        y_d   = d;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign y = y_q;

`ifdef FILTN_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = y_d & ~y_q;
    fall_d = ~y_d & y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/filtn.sv
// Multi-channel hysteresis glitch filter: CH independent filtn_ch slices.
// Define FILTN_EDGE_EN to add the rise/fall pulse outputs.
module filtn
  import filtn_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   N           = 3,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [CH-1:0] i,
  output logic [CH-1:0] y
`ifdef FILTN_EDGE_EN
  ,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
`endif
);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      filtn_ch #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .INIT        (INIT)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .i    (i[gi]),
        .y    (y[gi])
`ifdef FILTN_EDGE_EN
        ,
        .rise (rise[gi]),
        .fall (fall[gi])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_filtn.sv
// Self-checking bench for filtn: two instances (N=3/SYNC=0 and N=4/SYNC=2)
// checked every cycle against a run-length scoreboard plus directed checks.
module tb_filtn;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] i_v;
  logic [3:0] y_a, y_b;
`ifdef FILTN_EDGE_EN
  logic [3:0] rise_a, fall_a, rise_b, fall_b;
`endif

  always #5 clk = ~clk;

  filtn #(.CH(4), .N(3), .SYNC_STAGES(0), .INIT(1'b0)) dut_a (
    .clk (clk), .rst (rst), .ce (ce), .i (i_v), .y (y_a)
`ifdef FILTN_EDGE_EN
    , .rise (rise_a), .fall (fall_a)
`endif
  );

  filtn #(.CH(4), .N(4), .SYNC_STAGES(2), .INIT(1'b0)) dut_b (
    .clk (clk), .rst (rst), .ce (ce), .i (i_v), .y (y_b)
`ifdef FILTN_EDGE_EN
    , .rise (rise_b), .fall (fall_b)
`endif
  );

  typedef struct packed {
    logic [3:0] ya, ra, fa, yb, rb, fb;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_tick   = 0;
  int rise0_cnt;
  int fall1_cnt;

  // Reference state: filtered level, opposite-run length, input delay line.
  logic [3:0] m_y[2];
  logic [3:0] m_r[2];
  logic [3:0] m_f[2];
  int         m_run[2][4];
  logic [2:0] m_pipe[2][4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (tick %0d)", tag, got, exp, n_tick);
    end
  endtask

  task automatic model_edge(input int di, input logic r, input logic c, input logic [3:0] v);
    int   n;
    int   sync;
    logic d;
    n    = (di == 0) ? 3 : 4;
    sync = (di == 0) ? 0 : 2;
    for (int k = 0; k < 4; k++) begin
      m_r[di][k] = 1'b0;
      m_f[di][k] = 1'b0;
      if (r) begin
        m_y[di][k]    = 1'b0;
        m_run[di][k]  = 0;
        m_pipe[di][k] = 3'b000;
      end else begin
        d = (sync == 0) ? v[k] : m_pipe[di][k][sync-1];
        m_pipe[di][k] = {m_pipe[di][k][1:0], v[k]};
        if (c) begin
          if (d == m_y[di][k]) begin
            m_run[di][k] = 0;
          end else begin
            m_run[di][k]++;
            if (m_run[di][k] == n) begin
              m_y[di][k]   = d;
              m_run[di][k] = 0;
              m_r[di][k]   = d;
              m_f[di][k]   = ~d;
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic [3:0] v);
    exp_t e;
    exp_t x;
    rst = r;
    ce  = c;
    i_v = v;
    @(posedge clk);
    model_edge(0, r, c, v);
    model_edge(1, r, c, v);
    e.ya = m_y[0]; e.ra = m_r[0]; e.fa = m_f[0];
    e.yb = m_y[1]; e.rb = m_r[1]; e.fb = m_f[1];
    sb_q.push_back(e);
    @(negedge clk);
    n_tick++;
    x = sb_q.pop_front();
    $display("tick %0d rst=%b ce=%b i=%h y_a=%h y_b=%h", n_tick, r, c, v, y_a, y_b);
    chk("y_a", {28'd0, y_a}, {28'd0, x.ya});
    chk("y_b", {28'd0, y_b}, {28'd0, x.yb});
`ifdef FILTN_EDGE_EN
    chk("rise_a", {28'd0, rise_a}, {28'd0, x.ra});
    chk("fall_a", {28'd0, fall_a}, {28'd0, x.fa});
    chk("rise_b", {28'd0, rise_b}, {28'd0, x.rb});
    chk("fall_b", {28'd0, fall_b}, {28'd0, x.fb});
    if (rise_a[0]) rise0_cnt++;
    if (fall_a[1]) fall1_cnt++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       c_pat[6];
    logic [3:0] v;
    logic       r, c;
    int         k;

    rst = 1'b1; ce = 1'b0; i_v = 4'h0;
    for (int di = 0; di < 2; di++) begin
      m_y[di] = 4'h0; m_r[di] = 4'h0; m_f[di] = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        m_run[di][ch]  = 0;
        m_pipe[di][ch] = 3'b000;
      end
    end
    @(negedge clk);

    // Reset level, then release with all inputs high
    repeat (3) begin
      tick(1'b1, 1'b1, 4'hF);
      chk("rst_y_a", {28'd0, y_a}, 32'h0);
    end
    tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b1, 4'hF);
    chk("rel_edge2", {28'd0, y_a}, 32'h0);
    tick(1'b0, 1'b1, 4'hF);
    chk("rel_edge3", {28'd0, y_a}, 32'hF);

    // Glitch rejection on channel 0
    tick(1'b1, 1'b1, 4'h0);
    rise0_cnt = 0;
    repeat (2) tick(1'b0, 1'b1, 4'h1);
    repeat (4) tick(1'b0, 1'b1, 4'h0);
    chk("glitch_y0", {31'd0, y_a[0]}, 32'd0);
`ifdef FILTN_EDGE_EN
    chk("glitch_rise0", rise0_cnt, 32'd0);
`endif
    repeat (3) tick(1'b0, 1'b1, 4'h1);
    chk("pass_y0", {31'd0, y_a[0]}, 32'd1);
    repeat (2) tick(1'b0, 1'b1, 4'h1);
`ifdef FILTN_EDGE_EN
    chk("pass_rise0", rise0_cnt, 32'd1);
`endif

    // Hysteresis fall on channel 1: 0,0,1,0,0,0
    repeat (3) tick(1'b0, 1'b1, 4'h2);
    chk("hyst_y1_set", {31'd0, y_a[1]}, 32'd1);
    fall1_cnt = 0;
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h2);
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h0);
    chk("hyst_y1_hold", {31'd0, y_a[1]}, 32'd1);
    tick(1'b0, 1'b1, 4'h0);
    chk("hyst_y1_fall", {31'd0, y_a[1]}, 32'd0);
    tick(1'b0, 1'b1, 4'h0);
`ifdef FILTN_EDGE_EN
    chk("hyst_fall1", fall1_cnt, 32'd1);
`endif

    // Sample enable on channel 2
    tick(1'b1, 1'b1, 4'h0);
    c_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 6; j++) begin
      tick(1'b0, c_pat[j], 4'h4);
      if (j == 4) chk("ce_y2_hold", {31'd0, y_a[2]}, 32'd0);
      if (j == 5) chk("ce_y2_rise", {31'd0, y_a[2]}, 32'd1);
    end

    // Synchroniser latency on instance b, channel 3
    tick(1'b1, 1'b1, 4'h0);
    repeat (6) tick(1'b0, 1'b1, 4'h0);
    k = 0;
    do begin
      tick(1'b0, 1'b1, 4'h8);
      k++;
    end while (!y_b[3] && k < 20);
    chk("sync_latency", k, 32'd6);
    chk("sync_others", {29'd0, y_b[2:0]}, 32'd0);

    // Reset in the middle of a run
    tick(1'b1, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b1, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 4'h1);
    chk("midrst_early", {31'd0, y_a[0]}, 32'd0);
    tick(1'b0, 1'b1, 4'h1);
    chk("midrst_rise", {31'd0, y_a[0]}, 32'd1);

    // Random slow-changing inputs with sparse ce drops and resets
    v = 4'h1;
    repeat (300) begin
      r = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) v[b] = ~v[b];
      tick(r, c, v);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
